// File: rtl/periph_write_ctrl.sv
// Write-side bridge for the peripheral I/O window: store decode, writable
// registers, ADC start strobe and the prescaled down-counting timer.
module periph_write_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned PRESCALE  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        adc_busy,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        adc_start,
  output logic        timer_irq,
  output logic [31:0] ADC_control,
  output logic [31:0] siete_segmentos,
  output logic [31:0] LEDs,
  output logic [31:0] Timer
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] SLOT_ADC_CTRL = 3'd0;
  localparam logic [2:0] SLOT_SEG      = 3'd3;
  localparam logic [2:0] SLOT_LEDS     = 3'd4;
  localparam logic [2:0] SLOT_TIMER    = 3'd6;

  logic [31:0]   reload_q;
  logic [PW-1:0] presc_q;

  logic          wr_c;
  logic [2:0]    slot_c;
  logic          unused_addr_c;

  logic          ack_n, err_n, start_n, irq_n;
  logic [31:0]   adc_ctrl_n, seg_n, leds_n, reload_n, count_n;
  logic [PW-1:0] presc_n;

  // Byte lanes are ignored: full-word stores only.
  assign unused_addr_c = ^addr[1:0];
  assign wr_c          = wr_en && (addr[31:5] == BASE_ADDR[31:5]);
  assign slot_c        = addr[4:2];

  // Next-state: timer advance first, then a store may override it.
  always_comb begin
    ack_n      = 1'b0;
    err_n      = 1'b0;
    start_n    = 1'b0;
    irq_n      = 1'b0;
    adc_ctrl_n = ADC_control;
    seg_n      = siete_segmentos;
    leds_n     = LEDs;
    reload_n   = reload_q;
    count_n    = Timer;
    presc_n    = presc_q;

    if (reload_q != 32'd0) begin
      if (presc_q == PRESC_LAST) begin
        presc_n = '0;
        if (Timer > 32'd1) begin
          count_n = Timer - 32'd1;
        end else if (Timer == 32'd1) begin
          count_n = reload_q;
          irq_n   = 1'b1;
        end
      end else begin
        presc_n = presc_q + PW'(1);
      end
    end

    if (wr_c) begin
      case (slot_c)
        SLOT_ADC_CTRL: begin
          if (wr_data[0] && adc_busy) begin
            err_n = 1'b1;
          end else begin
            adc_ctrl_n = {wr_data[31:1], 1'b0};
            start_n    = wr_data[0];
            ack_n      = 1'b1;
          end
        end
        SLOT_SEG: begin
          seg_n = wr_data;
          ack_n = 1'b1;
        end
        SLOT_LEDS: begin
          leds_n = wr_data;
          ack_n  = 1'b1;
        end
        SLOT_TIMER: begin
          // A store on the expiry edge wins and suppresses the interrupt.
          reload_n = wr_data;
          count_n  = wr_data;
          presc_n  = '0;
          irq_n    = 1'b0;
          ack_n    = 1'b1;
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ack          <= 1'b0;
      wr_err          <= 1'b0;
      adc_start       <= 1'b0;
      timer_irq       <= 1'b0;
      ADC_control     <= 32'd0;
      siete_segmentos <= 32'd0;
      LEDs            <= 32'd0;
      Timer           <= 32'd0;
      reload_q        <= 32'd0;
      presc_q         <= '0;
    end else begin
      wr_ack          <= ack_n;
      wr_err          <= err_n;
      adc_start       <= start_n;
      timer_irq       <= irq_n;
      ADC_control     <= adc_ctrl_n;
      siete_segmentos <= seg_n;
      LEDs            <= leds_n;
      Timer           <= count_n;
      reload_q        <= reload_n;
      presc_q         <= presc_n;
    end
  end

endmodule

// File: tb/tb_periph_write_ctrl.sv
// Self-checking bench for periph_write_ctrl: directed scenarios followed by
// random stores, compared every cycle against an arithmetic reference model.
module tb_periph_write_ctrl;

  localparam int unsigned P    = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, adc_busy;
  logic [31:0] addr, wr_data;
  logic        wr_ack, wr_err, adc_start, timer_irq;
  logic [31:0] ADC_control, siete_segmentos, LEDs, Timer;

  always #5 clk = ~clk;

  periph_write_ctrl #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .adc_busy(adc_busy), .wr_ack(wr_ack), .wr_err(wr_err), .adc_start(adc_start),
    .timer_irq(timer_irq), .ADC_control(ADC_control),
    .siete_segmentos(siete_segmentos), .LEDs(LEDs), .Timer(Timer)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: timer described as elapsed edges since the last load.
  logic [31:0] m_adc, m_seg, m_led, m_reload, m_timer;
  logic        m_ack, m_err, m_start, m_irq;
  longint      m_el;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] slot;
    if (!rst_n) begin
      m_adc = 0; m_seg = 0; m_led = 0; m_reload = 0; m_timer = 0; m_el = 0;
      m_ack = 0; m_err = 0; m_start = 0; m_irq = 0;
      return;
    end
    m_ack = 0; m_err = 0; m_start = 0; m_irq = 0;
    if (m_reload != 0) begin
      m_el++;
      m_irq = ((m_el % (longint'(m_reload) * P)) == 0);
    end
    if (wr_en && (addr[31:5] == BASE[31:5])) begin
      slot = addr[4:2];
      case (slot)
        3'd0: if (wr_data[0] && adc_busy) m_err = 1;
              else begin m_adc = wr_data & ~32'd1; m_start = wr_data[0]; m_ack = 1; end
        3'd3: begin m_seg = wr_data; m_ack = 1; end
        3'd4: begin m_led = wr_data; m_ack = 1; end
        3'd6: begin m_reload = wr_data; m_el = 0; m_irq = 0; m_ack = 1; end
        default: m_err = 1;
      endcase
    end
    if (m_reload == 0) m_timer = 0;
    else m_timer = 32'(longint'(m_reload) - ((m_el / P) % longint'(m_reload)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("wr_ack", 32'(wr_ack), 32'(m_ack));
    check("wr_err", 32'(wr_err), 32'(m_err));
    check("adc_start", 32'(adc_start), 32'(m_start));
    check("timer_irq", 32'(timer_irq), 32'(m_irq));
    check("ADC_control", ADC_control, m_adc);
    check("siete_segmentos", siete_segmentos, m_seg);
    check("LEDs", LEDs, m_led);
    check("Timer", Timer, m_timer);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic busy);
    wr_en = 1'b1; addr = a; wr_data = d; adc_busy = busy;
    tick();
    wr_en = 1'b0; adc_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; adc_busy = 1'b0;
    m_adc = 0; m_seg = 0; m_led = 0; m_reload = 0; m_timer = 0; m_el = 0;
    m_ack = 0; m_err = 0; m_start = 0; m_irq = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset mid-count, with a store presented during reset that must be dropped.
    store(BASE + 32'h18, 32'd5, 1'b0);
    idle(2 * P);
    check("timer_mid", Timer, 32'd3);
    rst_n = 1'b0;
    store(BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    rst_n = 1'b1;
    check("timer_after_rst", Timer, 32'd0);
    check("leds_after_rst", LEDs, 32'd0);
    idle(6 * P);

    // Writable slots.
    store(BASE + 32'h10, 32'hA5A5_0003, 1'b0);
    check("leds_direct", LEDs, 32'hA5A5_0003);
    store(BASE + 32'h0C, 32'h0000_007F, 1'b0);
    check("seg_direct", siete_segmentos, 32'h0000_007F);
    idle(1);

    // ADC start, idle then busy.
    store(BASE + 32'h00, 32'h0000_0011, 1'b0);
    check("adc_ctrl_direct", ADC_control, 32'h0000_0010);
    idle(1);
    store(BASE + 32'h00, 32'h0000_0011, 1'b1);
    idle(1);

    // Read-only / reserved slots and outside the window, back to back.
    store(BASE + 32'h04, 32'h1111_1111, 1'b0);
    store(BASE + 32'h08, 32'h2222_2222, 1'b0);
    store(BASE + 32'h14, 32'h3333_3333, 1'b0);
    store(BASE + 32'h1C, 32'h4444_4444, 1'b0);
    store(BASE + 32'h20, 32'h5555_5555, 1'b0);
    idle(1);

    // Timer periodic with reload 3, then disable.
    store(BASE + 32'h18, 32'd3, 1'b0);
    idle(3 * 3 * P + 2);
    store(BASE + 32'h18, 32'd0, 1'b0);
    idle(4 * P);

    // Store on the exact expiry edge (elapsed = 3*P).
    store(BASE + 32'h18, 32'd3, 1'b0);
    idle(3 * P - 1);
    store(BASE + 32'h18, 32'd7, 1'b0);
    check("collision_timer", Timer, 32'd7);
    check("collision_irq", 32'(timer_irq), 32'd0);
    idle(7 * P + 2);

    // Random stores, occasional resets.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      if (sel <= 7)      a = BASE + 32'(sel * 4);
      else if (sel == 8) a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
      else               a = $urandom;
      d = $urandom;
      if (a[4:2] == 3'd6) d = 32'($urandom_range(0, 5));
      rst_n    = ($urandom_range(0, 59) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      addr     = a;
      wr_data  = d;
      adc_busy = $urandom_range(0, 1) == 1;
      tick();
    end
    rst_n = 1'b1; wr_en = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
